// File: rtl/serial_compare_rx_if.sv
// Bundle between a bit-serial producer and serial_compare_rx.
// Optional ordering outputs appear when SERIAL_COMPARE_MAGNITUDE_EN is defined.
interface serial_compare_rx_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic             key;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic             done;
  logic             result;
  logic             equal;
  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;
  logic [1:0]       state_dbg;
`ifdef SERIAL_COMPARE_MAGNITUDE_EN
  logic             a_gt_b;
  logic             a_lt_b;

  modport master (
    output start, key, bit_valid, a_bit, b_bit,
    input  busy, done, result, equal, a_word, b_word, state_dbg, a_gt_b, a_lt_b
  );
  modport slave (
    input  start, key, bit_valid, a_bit, b_bit,
    output busy, done, result, equal, a_word, b_word, state_dbg, a_gt_b, a_lt_b
  );
`else
  modport master (
    output start, key, bit_valid, a_bit, b_bit,
    input  busy, done, result, equal, a_word, b_word, state_dbg
  );
  modport slave (
    input  start, key, bit_valid, a_bit, b_bit,
    output busy, done, result, equal, a_word, b_word, state_dbg
  );
`endif
endinterface

// File: rtl/serial_compare_rx.sv
// Bit-serial (MSB first) equality compare receiver; key selects equal / not-equal.
// Define SERIAL_COMPARE_MAGNITUDE_EN to add a_gt_b / a_lt_b ordering outputs.
module serial_compare_rx #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               reset,
  serial_compare_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic             r_key;
  logic             r_mis;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_result;
  logic             r_equal;

  logic w_accept;
  logic w_beat;
  logic w_last;
  logic w_diff;
  logic w_mis_next;

  // Handshake: a beat transfers on any cycle in SHIFT with bit_valid high; no backpressure.
  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_beat     = (r_state == S_SHIFT) && bus.bit_valid;
  assign w_last     = w_beat && (r_cnt == CW'(1));
  assign w_diff     = bus.a_bit ^ bus.b_bit;
  assign w_mis_next = r_mis | w_diff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_SHIFT;
      S_SHIFT: if (w_last)    w_state_next = S_DONE;
      S_DONE:                 w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_key    <= 1'b0;
      r_mis    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= 1'b0;
      r_equal  <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= CW'(WIDTH);
      r_key    <= bus.key;
      r_mis    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= 1'b0;
      r_equal  <= 1'b0;
    end else if (w_beat) begin
      r_a   <= {r_a[WIDTH-2:0], bus.a_bit};
      r_b   <= {r_b[WIDTH-2:0], bus.b_bit};
      r_mis <= w_mis_next;
      r_cnt <= r_cnt - CW'(1);
      // Final beat: results come from the mismatch including this beat.
      if (w_last) begin
        r_equal  <= ~w_mis_next;
        r_result <= r_key ? w_mis_next : ~w_mis_next;
      end
    end
  end

`ifdef SERIAL_COMPARE_MAGNITUDE_EN
  logic r_ord_gt;
  logic r_ord_lt;
  logic r_a_gt_b;
  logic r_a_lt_b;
  logic w_gt_next;
  logic w_lt_next;

  // Ordering is decided by the first differing bit; r_mis marks that it is already fixed.
  assign w_gt_next = r_mis ? r_ord_gt : (bus.a_bit & ~bus.b_bit);
  assign w_lt_next = r_mis ? r_ord_lt : (~bus.a_bit & bus.b_bit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ord_gt <= 1'b0;
      r_ord_lt <= 1'b0;
      r_a_gt_b <= 1'b0;
      r_a_lt_b <= 1'b0;
    end else if (w_accept) begin
      r_ord_gt <= 1'b0;
      r_ord_lt <= 1'b0;
      r_a_gt_b <= 1'b0;
      r_a_lt_b <= 1'b0;
    end else if (w_beat) begin
      r_ord_gt <= w_gt_next;
      r_ord_lt <= w_lt_next;
      if (w_last) begin
        r_a_gt_b <= w_gt_next;
        r_a_lt_b <= w_lt_next;
      end
    end
  end

  assign bus.a_gt_b = r_a_gt_b;
  assign bus.a_lt_b = r_a_lt_b;
`endif

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.equal     = r_equal;
  assign bus.a_word    = r_a;
  assign bus.b_word    = r_b;
  assign bus.state_dbg = r_state;
endmodule
